// File: rtl/otter_pkg.sv
// Shared types for the OTTER multicycle control unit: opcodes, FSM states,
// privileged funct3 codes and the instruction classes the FSM acts on.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_OP     = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

  localparam logic [2:0] FUNC3_CSRRW = 3'b001;
  localparam logic [2:0] FUNC3_PRIV  = 3'b000;

  typedef enum logic [2:0] {
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_ALU,
    C_CSRRW,
    C_MRET,
    C_NOP
  } inst_class_t;

endpackage

// File: rtl/otter_cu_fsm_if.sv
// Control-unit side bundle: decoder/CSR inputs into the FSM and the strobes
// it drives to the PC, memory, register file and CSR blocks.
interface otter_cu_fsm_if;

  logic       RST;
  logic [6:0] OPCODE;
  logic [2:0] FUNC3;
  logic       INTR;
  logic       MIE;

  logic       PC_RESET;
  logic       PC_WRITE;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       REG_WRITE;
  logic       CSR_WE;
  logic       MRET_EXEC;
  logic       INT_TAKEN;
  logic [2:0] STATE;

  modport master (
    input  RST, OPCODE, FUNC3, INTR, MIE,
    output PC_RESET, PC_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, MRET_EXEC, INT_TAKEN, STATE
  );

  modport slave (
    output RST, OPCODE, FUNC3, INTR, MIE,
    input  PC_RESET, PC_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, MRET_EXEC, INT_TAKEN, STATE
  );

endinterface

// File: rtl/otter_cu_decode.sv
// Collapses OPCODE/FUNC3 into the instruction class the control FSM needs;
// anything unrecognised becomes C_NOP rather than trapping.
module otter_cu_decode
  import otter_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  output inst_class_t inst_class
);

  always_comb begin
    inst_class = C_NOP;
    case (opcode)
      OP_LOAD:   inst_class = C_LOAD;
      OP_STORE:  inst_class = C_STORE;
      OP_BRANCH: inst_class = C_BRANCH;
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                 inst_class = C_ALU;
      OP_SYSTEM: begin
        if (func3 == FUNC3_CSRRW)
          inst_class = C_CSRRW;
        else if (func3 == FUNC3_PRIV)
          inst_class = C_MRET;
      end
      default:   inst_class = C_NOP;
    endcase
  end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: INIT -> FETCH -> EXEC (-> WB) with optional
// interrupt entry, compiled in only when OTTER_INTR_EN is defined.
module otter_cu_fsm
  import otter_pkg::*;
#(
  parameter int unsigned INIT_CYCLES      = 1,
  parameter int unsigned LOAD_WAIT_CYCLES = 1
) (
  input logic             CLK,
  input logic             RESET_N,
  otter_cu_fsm_if.master  cu
);

  localparam int unsigned MAX_CYC = (INIT_CYCLES > LOAD_WAIT_CYCLES) ? INIT_CYCLES : LOAD_WAIT_CYCLES;
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(LOAD_WAIT_CYCLES - 1);

  cu_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  inst_class_t      inst_class;
  logic             intr_req;
  cu_state_t        done_state;

  logic pc_reset, pc_write, mem_rden1, mem_rden2, mem_we2;
  logic reg_write, csr_we, mret_exec, int_taken;

  otter_cu_decode u_decode (
    .opcode     (cu.OPCODE),
    .func3      (cu.FUNC3),
    .inst_class (inst_class)
  );

`ifdef OTTER_INTR_EN
  assign intr_req = cu.INTR & cu.MIE;
`else
  logic unused_intr;
  assign unused_intr = cu.INTR ^ cu.MIE;
  assign intr_req    = 1'b0;
`endif

  // Where an instruction goes once it has retired: interrupt entry or the next fetch.
  assign done_state = intr_req ? ST_INTR : ST_FETCH;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (inst_class == C_LOAD) begin
          state_d = ST_WB;
          cnt_d   = '0;
        end else begin
          state_d = done_state;
        end
      end
      ST_WB: begin
        if (cnt_q == WB_LAST) begin
          state_d = done_state;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef OTTER_INTR_EN
      ST_INTR: state_d = ST_FETCH;
`endif
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    if (cu.RST) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes are decoded straight from the current state and instruction class.
  always_comb begin
    pc_reset  = 1'b0;
    pc_write  = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    reg_write = 1'b0;
    csr_we    = 1'b0;
    mret_exec = 1'b0;
    int_taken = 1'b0;
    case (state_q)
      ST_INIT:  pc_reset  = 1'b1;
      ST_FETCH: mem_rden1 = 1'b1;
      ST_EXEC: begin
        case (inst_class)
          C_LOAD:   mem_rden2 = 1'b1;
          C_STORE: begin
            mem_we2  = 1'b1;
            pc_write = 1'b1;
          end
          C_ALU: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
          end
          C_CSRRW: begin
            reg_write = 1'b1;
            csr_we    = 1'b1;
            pc_write  = 1'b1;
          end
          C_MRET: begin
            mret_exec = 1'b1;
            pc_write  = 1'b1;
          end
          default:  pc_write = 1'b1;
        endcase
      end
      ST_WB: begin
        if (cnt_q == WB_LAST) begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
      end
`ifdef OTTER_INTR_EN
      ST_INTR: begin
        pc_write  = 1'b1;
        int_taken = 1'b1;
      end
`endif
      default: ;
    endcase
    // A soft reset must not commit any architectural state, even mid-load.
    if (cu.RST) begin
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_we2   = 1'b0;
      csr_we    = 1'b0;
    end
  end

  assign cu.PC_RESET  = pc_reset;
  assign cu.PC_WRITE  = pc_write;
  assign cu.MEM_RDEN1 = mem_rden1;
  assign cu.MEM_RDEN2 = mem_rden2;
  assign cu.MEM_WE2   = mem_we2;
  assign cu.REG_WRITE = reg_write;
  assign cu.CSR_WE    = csr_we;
  assign cu.MRET_EXEC = mret_exec;
  assign cu.INT_TAKEN = int_taken;
  assign cu.STATE     = state_q;

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multicycle control-unit state machine for the OTTER core.
- Sequences the program-counter register: drives its write enable and reset.
- Also sequences instruction/data memory strobes, register-file write and CSR write.
- Handles external interrupt entry.
- Sits beside the decoder; its outputs feed the PC, memory, register file and CSR blocks directly.

Parameters:
- INIT_CYCLES, 1, cycles held in INIT (PC held in reset) before the first fetch; minimum 1.
- LOAD_WAIT_CYCLES, 1, cycles spent in WB waiting on data-memory read latency; minimum 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- RST  in  1  synchronous soft-reset request (button), active-high.
- OPCODE  in  7  instruction bits [6:0], valid in EXEC.
- FUNC3  in  3  instruction bits [14:12], valid in EXEC.
- INTR  in  1  external interrupt request, level.
- MIE  in  1  CSR mstatus.MIE.
- PC_RESET  out  1  drives PC reset.
- PC_WRITE  out  1  PC load enable.
- MEM_RDEN1  out  1  instruction memory read.
- MEM_RDEN2  out  1  data memory read.
- MEM_WE2  out  1  data memory write.
- REG_WRITE  out  1  register-file write.
- CSR_WE  out  1  CSR write.
- MRET_EXEC  out  1  mret executing.
- INT_TAKEN  out  1  interrupt entry (PC mux selects mtvec; CSR saves mepc).
- STATE  out  3  current state encoding, for debug.

Behaviour:

States:
- INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4.
- Outputs are combinational from state, OPCODE and FUNC3.
- Every strobe not listed for a state is 0.

Reset:
- RESET_N low (asynchronous) → state INIT, counters cleared.
- While in reset: PC_RESET=1, all other outputs 0, STATE=0.

INIT:
- PC_RESET=1.
- Stays INIT_CYCLES cycles, then → FETCH.

FETCH:
- MEM_RDEN1=1 for one cycle.
- → EXEC.

EXEC, decoded from OPCODE:
- LOAD 0000011: MEM_RDEN2=1; PC_WRITE=0; → WB.
- STORE 0100011: MEM_WE2=1, PC_WRITE=1.
- BRANCH 1100011: PC_WRITE=1.
- OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: REG_WRITE=1, PC_WRITE=1.
- SYSTEM 1110011 with FUNC3=001 (csrrw): REG_WRITE=1, CSR_WE=1, PC_WRITE=1.
- SYSTEM 1110011 with FUNC3=000 (mret): MRET_EXEC=1, PC_WRITE=1.
- Any other opcode or SYSTEM funct3: PC_WRITE=1 only (executes as a nop, no trap).
- Non-load next state: → INTR if INTR&MIE, else → FETCH.

WB:
- Stays LOAD_WAIT_CYCLES cycles. Strobes are 0 until the final cycle.
- Final cycle: REG_WRITE=1, PC_WRITE=1.
- Next state: → INTR if INTR&MIE, else → FETCH.

INTR:
- PC_WRITE=1, INT_TAKEN=1 for exactly one cycle.
- → FETCH.

Interrupt sampling:
- Sampled only on the last cycle of an instruction (EXEC of a non-load, or the final WB cycle).
- INTR in FETCH, INIT, or a non-final WB cycle is not taken until that point.
- INTR while in INTR is ignored; CSR clears MIE on entry.
- INTR&MIE during mret EXEC: mret completes (PC_WRITE, MRET_EXEC), then → INTR.

Soft reset:
- RST=1 in any state: next state INIT, counters reloaded.
- In the cycle RST is high: PC_WRITE, REG_WRITE, MEM_WE2 and CSR_WE are forced to 0. This includes mid-load in WB.
- RST during INIT restarts the INIT count.

Invariants:
- Exactly one PC_WRITE pulse per retired instruction or interrupt entry.
- PC_WRITE and PC_RESET are never both 1.

Optional Feature:
- Macro: OTTER_INTR_EN.
- Defined: INTR state and interrupt sampling present, as above.
- Undefined:
  - INTR and MIE are ignored.
  - INTR state is unreachable; encoding 4 is unused, and an illegal state returns to INIT.
  - INT_TAKEN is tied to 0.
  - EXEC and WB always go → FETCH.

Decomposition:
- Package otter_pkg:
  - opcode_t enum (7-bit values above).
  - cu_state_t enum (3-bit).
  - FUNC3_CSRRW=3'b001, FUNC3_PRIV=3'b000.
  - inst_class_t enum {C_LOAD, C_STORE, C_BRANCH, C_ALU, C_CSRRW, C_MRET, C_NOP}.
- Sub-module otter_cu_decode: combinational OPCODE/FUNC3 → inst_class_t.
- The FSM consumes only the class, not raw bits.

Test Plan:
- Reset: RESET_N low 3 cycles → PC_RESET=1, STATE=0; release → one INIT cycle, then FETCH with MEM_RDEN1=1.
- ADDI (0010011): FETCH, EXEC with REG_WRITE=1 and PC_WRITE=1, back to FETCH; 2 cycles per instruction.
- LW with LOAD_WAIT_CYCLES=2: EXEC MEM_RDEN2=1; WB cycle 1 all strobes 0; WB cycle 2 REG_WRITE=1, PC_WRITE=1; 4 cycles total.
- Interrupt: INTR=1, MIE=1 asserted during FETCH of BEQ → EXEC PC_WRITE=1, then INTR state with INT_TAKEN=1 and PC_WRITE=1, then FETCH. With MIE=0 → no INTR state.
- Soft reset mid-load: RST=1 on WB cycle 1 → no REG_WRITE/PC_WRITE that cycle; next state INIT with PC_RESET=1.
- Build without OTTER_INTR_EN: INTR=MIE=1 held continuously → INT_TAKEN stays 0, STATE never equals 4.
